// File: rtl/pld_pkg.sv
// Shared types and defaults for the var2 sweep controller.
package pld_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_CHECK = 2'd3
    } sweep_state_t;

    localparam int N_IN_DEF     = 5;
    localparam int EVAL_LAT_DEF = 2;

endpackage

// File: rtl/var2_idx_pipe.sv
// Delay line for {valid, index} that keeps each vector index aligned with
// the evaluator result it produces.
module var2_idx_pipe
    import pld_pkg::*;
#(
    parameter int IW    = N_IN_DEF,
    parameter int DEPTH = EVAL_LAT_DEF + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_valid,
    input  logic [IW-1:0] i_idx,
    output logic          o_valid,
    output logic [IW-1:0] o_idx,
    output logic          o_pend
);

    logic [DEPTH-1:0] r_valid;
    logic [IW-1:0]    r_idx [DEPTH];

    // Shift valid and index one stage per clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            for (int k = 0; k < DEPTH; k++) r_idx[k] <= '0;
        end else begin
            r_valid  <= {r_valid[DEPTH-2:0], i_valid};
            r_idx[0] <= i_idx;
            for (int k = 1; k < DEPTH; k++) r_idx[k] <= r_idx[k-1];
        end
    end

    assign o_valid = r_valid[DEPTH-1];
    assign o_idx   = r_idx[DEPTH-1];
    // Anything still in flight behind the output stage; once clear, the
    // output stage is the last entry and is consumed on the coming edge.
    assign o_pend  = |r_valid[DEPTH-2:0];

endmodule

// File: rtl/var2_sweep_ctrl.sv
// Exhaustive sweep sequencer for a registered N_IN-input boolean evaluator.
// Drives every input vector once, rebuilds the truth table from the delayed
// results and compares it against an expected table.
//
//   state | meaning
//   IDLE  | eval_in=0, results held, waits for start
//   DRIVE | presents vector eval_in, one per cycle, 0 .. 2**N_IN-1
//   DRAIN | eval_in=0, waits for in-flight results to land
//   CHECK | one cycle, latches pass, raises done on the next cycle
module var2_sweep_ctrl
    import pld_pkg::*;
#(
    parameter int N_IN     = N_IN_DEF,
    parameter int EVAL_LAT = EVAL_LAT_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_start,
    input  logic [(2**N_IN)-1:0] i_exp_table,
    output logic [N_IN-1:0]      o_eval_in,
    input  logic                 i_eval_out,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [(2**N_IN)-1:0] o_table,
    output logic [N_IN:0]        o_ones,
    output logic                 o_pass,
    output logic                 o_err_valid,
    output logic [N_IN-1:0]      o_err_idx
);

    localparam logic [N_IN-1:0] V_ONE  = {{(N_IN-1){1'b0}}, 1'b1};
    localparam logic [N_IN-1:0] V_LAST = '1;

    sweep_state_t          r_state;
    sweep_state_t          w_nxt_state;
    logic [N_IN-1:0]       r_eval_in;
    logic [N_IN-1:0]       w_nxt_eval_in;
    logic                  w_nxt_valid;
    logic                  w_clear;
    logic                  w_check;
    logic                  r_done;

    logic                  w_cap_valid;
    logic [N_IN-1:0]       w_cap_idx;
    logic                  w_pend;
    logic [N_IN:0]         w_ones_inc;

    logic [(2**N_IN)-1:0]  r_table;
    logic [N_IN:0]         r_ones;
    logic                  r_pass;
    logic                  r_err_valid;
    logic [N_IN-1:0]       r_err_idx;

    // State, presented vector and done pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_eval_in <= '0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_nxt_state;
            r_eval_in <= w_nxt_eval_in;
            r_done    <= w_check;
        end
    end

    // Next state, next vector and the clear/check strobes.
    always_comb begin
        w_nxt_state   = r_state;
        w_nxt_eval_in = '0;
        w_nxt_valid   = 1'b0;
        w_clear       = 1'b0;
        w_check       = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_nxt_state = ST_DRIVE;
                    w_nxt_valid = 1'b1;
                    w_clear     = 1'b1;
                end
            end
            ST_DRIVE: begin
                // The vector register doubles as the sweep counter; the last
                // vector ends the sweep instead of wrapping back to zero.
                if (r_eval_in == V_LAST) begin
                    w_nxt_state = ST_DRAIN;
                end else begin
                    w_nxt_eval_in = r_eval_in + V_ONE;
                    w_nxt_valid   = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (!w_pend) w_nxt_state = ST_CHECK;
            end
            ST_CHECK: begin
                w_check     = 1'b1;
                w_nxt_state = ST_IDLE;
            end
            default: w_nxt_state = ST_IDLE;
        endcase
    end

    // Fed from the next-vector values, so the extra stage stands in for the
    // vector register and the output lines up with the evaluator result.
    var2_idx_pipe #(
        .IW    (N_IN),
        .DEPTH (EVAL_LAT + 1)
    ) u_idx_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (w_nxt_valid),
        .i_idx   (w_nxt_eval_in),
        .o_valid (w_cap_valid),
        .o_idx   (w_cap_idx),
        .o_pend  (w_pend)
    );

    assign w_ones_inc = {{N_IN{1'b0}}, i_eval_out};

    // Capture results into the table, count ones, record the first mismatch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_table     <= '0;
            r_ones      <= '0;
            r_pass      <= 1'b0;
            r_err_valid <= 1'b0;
            r_err_idx   <= '0;
        end else if (w_clear) begin
            r_table     <= '0;
            r_ones      <= '0;
            r_pass      <= 1'b0;
            r_err_valid <= 1'b0;
            r_err_idx   <= '0;
        end else begin
            if (w_cap_valid) begin
                r_table[w_cap_idx] <= i_eval_out;
                r_ones             <= r_ones + w_ones_inc;
                // Indices arrive in ascending order, so the first one kept
                // is the lowest mismatching index.
                if ((i_eval_out != i_exp_table[w_cap_idx]) && !r_err_valid) begin
                    r_err_valid <= 1'b1;
                    r_err_idx   <= w_cap_idx;
                end
            end
            if (w_check) r_pass <= ~r_err_valid;
        end
    end

    assign o_eval_in   = r_eval_in;
    assign o_busy      = (r_state != ST_IDLE);
    assign o_done      = r_done;
    assign o_table     = r_table;
    assign o_ones      = r_ones;
    assign o_pass      = r_pass;
    assign o_err_valid = r_err_valid;
    assign o_err_idx   = r_err_idx;

endmodule

// File: tb/tb_var2_sweep_ctrl.sv
// Directed bench for var2_sweep_ctrl: one instance at EVAL_LAT=2 with a
// two-stage evaluator model, one at EVAL_LAT=1 with a one-stage model.
module tb_var2_sweep_ctrl;

    localparam logic [31:0] F_TBL = 32'hF1F1F10E;

    typedef struct {
        string       tag;
        logic [31:0] tbl;
        logic [5:0]  ones;
        logic        pass;
        logic        ev;
        logic [4:0]  ei;
    } exp_t;

    exp_t sb[$];

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        sel = 1'b0;
    logic [31:0] exp_tbl = F_TBL;
    int          mode = 0;
    int          cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;

    logic [4:0]  ein0, ein1, ei0, ei1;
    logic        eout0, eout1, busy0, busy1, done0, done1;
    logic        pass0, pass1, ev0, ev1;
    logic [31:0] tbl0, tbl1;
    logic [5:0]  ones0, ones1;

    logic        m0_s1 = 1'b0, m0_q = 1'b0, m1_q = 1'b0;

    var2_sweep_ctrl #(.N_IN(5), .EVAL_LAT(2)) dut (
        .clk(clk), .rst_n(rst_n), .i_start(start & ~sel), .i_exp_table(exp_tbl),
        .o_eval_in(ein0), .i_eval_out(eout0), .o_busy(busy0), .o_done(done0),
        .o_table(tbl0), .o_ones(ones0), .o_pass(pass0), .o_err_valid(ev0),
        .o_err_idx(ei0)
    );

    var2_sweep_ctrl #(.N_IN(5), .EVAL_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .i_start(start & sel), .i_exp_table(exp_tbl),
        .o_eval_in(ein1), .i_eval_out(eout1), .o_busy(busy1), .o_done(done1),
        .o_table(tbl1), .o_ones(ones1), .o_pass(pass1), .o_err_valid(ev1),
        .o_err_idx(ei1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic fmodel(input logic [4:0] v);
        logic [31:0] t;
        t = F_TBL;
        return t[v];
    endfunction

    // Evaluator models: var2 truth table, optionally stuck at 0 or 1.
    always @(posedge clk) begin
        m0_s1 <= fmodel(ein0);
        m0_q  <= m0_s1;
        m1_q  <= fmodel(ein1);
    end
    assign eout0 = (mode == 1) ? 1'b0 : (mode == 2) ? 1'b1 : m0_q;
    assign eout1 = (mode == 1) ? 1'b0 : (mode == 2) ? 1'b1 : m1_q;

    wire [4:0]  s_eval_in = sel ? ein1  : ein0;
    wire        s_busy    = sel ? busy1 : busy0;
    wire        s_done    = sel ? done1 : done0;
    wire [31:0] s_table   = sel ? tbl1  : tbl0;
    wire [5:0]  s_ones    = sel ? ones1 : ones0;
    wire        s_pass    = sel ? pass1 : pass0;
    wire        s_ev      = sel ? ev1   : ev0;
    wire [4:0]  s_ei      = sel ? ei1   : ei0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_eval_in"},   {27'd0, s_eval_in}, 32'd0);
        chk({tag, "_busy"},      {31'd0, s_busy},    32'd0);
        chk({tag, "_done"},      {31'd0, s_done},    32'd0);
        chk({tag, "_table"},     s_table,            32'd0);
        chk({tag, "_ones"},      {26'd0, s_ones},    32'd0);
        chk({tag, "_pass"},      {31'd0, s_pass},    32'd0);
        chk({tag, "_err_valid"}, {31'd0, s_ev},      32'd0);
        chk({tag, "_err_idx"},   {27'd0, s_ei},      32'd0);
    endtask

    // Called at a negedge with the selected DUT idle. Raises start, walks the
    // sweep cycle by cycle and compares the finished result with the
    // scoreboard entry pushed at launch.
    task automatic sweep(input string tag, input logic [31:0] expt, input int md,
                         input logic [31:0] tbl, input logic [5:0] ones, input logic pass,
                         input logic ev, input logic [4:0] ei, input int lat,
                         input bit hold, input int pulse_at);
        exp_t e;
        int   e0;
        int   k;
        bit   seen;
        exp_tbl = expt;
        mode    = md;
        e.tag = tag; e.tbl = tbl; e.ones = ones; e.pass = pass; e.ev = ev; e.ei = ei;
        sb.push_back(e);
        start = 1'b1;
        e0    = cyc + 1;
        k     = -1;
        seen  = 1'b0;
        for (int n = 0; n < lat + 20 && !seen; n++) begin
            @(negedge clk);
            k = cyc - e0;
            if (!hold && k == 0) start = 1'b0;
            if (pulse_at >= 0 && k == pulse_at) start = 1'b1;
            if (pulse_at >= 0 && k == pulse_at + 1) start = 1'b0;
            if (s_done) begin
                seen = 1'b1;
            end else begin
                chk({tag, "_eval_in"}, {27'd0, s_eval_in}, (k < 32) ? k : 0);
                chk({tag, "_busy"},    {31'd0, s_busy},    32'd1);
            end
        end
        chk({tag, "_done_seen"},    {31'd0, seen},   32'd1);
        chk({tag, "_latency"},      k,               lat);
        chk({tag, "_busy_at_done"}, {31'd0, s_busy}, 32'd0);
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk({e.tag, "_table"},     s_table,         e.tbl);
            chk({e.tag, "_ones"},      {26'd0, s_ones}, {26'd0, e.ones});
            chk({e.tag, "_pass"},      {31'd0, s_pass}, {31'd0, e.pass});
            chk({e.tag, "_err_valid"}, {31'd0, s_ev},   {31'd0, e.ev});
            chk({e.tag, "_err_idx"},   {27'd0, s_ei},   {27'd0, e.ei});
        end
    endtask

    initial begin
        // Reset state.
        repeat (3) @(negedge clk);
        check_zero("rst");
        rst_n = 1'b1;
        @(negedge clk);

        // Matching table.
        sweep("t1", 32'hF1F1F10E, 0, 32'hF1F1F10E, 6'd18, 1'b1, 1'b0, 5'd0, 35, 1'b0, -1);
        @(negedge clk);
        chk("t1_done_pulse", {31'd0, s_done}, 32'd0);
        repeat (5) @(negedge clk);
        chk("t1_held_table", s_table, 32'hF1F1F10E);
        chk("t1_held_pass", {31'd0, s_pass}, 32'd1);

        // Mismatch at bit 0.
        sweep("t2", 32'hF1F1F10F, 0, 32'hF1F1F10E, 6'd18, 1'b0, 1'b1, 5'd0, 35, 1'b0, -1);
        // Evaluator stuck at 0.
        sweep("t3", 32'hF1F1F10E, 1, 32'h00000000, 6'd0, 1'b0, 1'b1, 5'd1, 35, 1'b0, -1);

        // start held: one sweep, then a second from the following edge;
        // a start pulse during DRIVE of the second sweep changes nothing.
        sweep("t4a", 32'hF1F1F10E, 0, 32'hF1F1F10E, 6'd18, 1'b1, 1'b0, 5'd0, 35, 1'b1, -1);
        sweep("t4b", 32'hF1F1F10E, 0, 32'hF1F1F10E, 6'd18, 1'b1, 1'b0, 5'd0, 35, 1'b0, 5);
        @(negedge clk);
        chk("t4_idle", {31'd0, s_busy}, 32'd0);

        // Reset in the middle of a sweep.
        exp_tbl = F_TBL;
        mode    = 0;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("t5_pre_busy", {31'd0, s_busy}, 32'd1);
        chk("t5_pre_table_nonzero", {31'd0, (s_table != 32'd0)}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_zero("t5_rst");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t5_no_done", {31'd0, s_done}, 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("t5_idle_done", {31'd0, s_done}, 32'd0);
        sweep("t5b", 32'hF1F1F10E, 0, 32'hF1F1F10E, 6'd18, 1'b1, 1'b0, 5'd0, 35, 1'b0, -1);

        // EVAL_LAT=1 instance.
        sel = 1'b1;
        @(negedge clk);
        sweep("t6", 32'hF1F1F10E, 0, 32'hF1F1F10E, 6'd18, 1'b1, 1'b0, 5'd0, 34, 1'b0, -1);
        sweep("t6b", 32'hF1F1F10E, 2, 32'hFFFFFFFF, 6'd32, 1'b0, 1'b1, 5'd0, 34, 1'b0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
